// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter: TDM arbiter sharing one synchronous single-port RAM among CHANNELS requesters.
// Define ARB_WORK_CONSERVING_EN to donate a slot whose owner is idle to the lowest eligible channel.
module shared_ram_arbiter #(
   parameter int CHANNELS = 2,
   parameter int ADDR_W   = 15,
   parameter int DATA_W   = 8,
   parameter int CH_W     = $clog2(CHANNELS)
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [CHANNELS-1:0]        REQ,
   input  logic [CHANNELS-1:0]        WE,
   input  logic [CHANNELS*ADDR_W-1:0] ADDR,
   input  logic [CHANNELS*DATA_W-1:0] WDATA,
   output logic [CHANNELS*DATA_W-1:0] RDATA,
   output logic [CHANNELS-1:0]        ACK,
   output logic [CH_W-1:0]            SLOT,
   output logic                       PHASE0,
   output logic [ADDR_W-1:0]          MEM_ADDR,
   output logic                       MEM_WE,
   output logic [DATA_W-1:0]          MEM_WDATA,
   input  logic [DATA_W-1:0]          MEM_RDATA
);
   logic [CH_W-1:0]     r_slot;
   logic [CHANNELS-1:0] r_busy;
   logic                r_v1, r_v2, r_we1, r_we2;
   logic [CH_W-1:0]     r_ch1, r_ch2;
   logic [CHANNELS-1:0] w_elig;
   logic                w_gnt;
   logic [CH_W-1:0]     w_gch;

   assign w_elig = REQ & ~r_busy;
   assign SLOT   = r_slot;
   assign PHASE0 = (r_slot == '0);

`ifdef ARB_WORK_CONSERVING_EN
   // owner keeps its slot; otherwise the lowest-indexed eligible channel takes it
   always_comb begin
      w_gnt = |w_elig;
      w_gch = r_slot;
      if (!w_elig[r_slot])
         for (int i = CHANNELS - 1; i >= 0; i--)
            if (w_elig[i]) w_gch = CH_W'(i);
   end
`else
   assign w_gnt = w_elig[r_slot];
   assign w_gch = r_slot;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_slot    <= '0;
         r_busy    <= '0;
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_we1     <= 1'b0;
         r_we2     <= 1'b0;
         r_ch1     <= '0;
         r_ch2     <= '0;
         ACK       <= '0;
         RDATA     <= '0;
         MEM_ADDR  <= '0;
         MEM_WE    <= 1'b0;
         MEM_WDATA <= '0;
      end else begin
         r_slot <= (r_slot == CH_W'(CHANNELS - 1)) ? '0 : r_slot + CH_W'(1);
         MEM_WE <= w_gnt && WE[w_gch];
         if (w_gnt) begin
            MEM_ADDR  <= ADDR[w_gch*ADDR_W +: ADDR_W];
            MEM_WDATA <= WDATA[w_gch*DATA_W +: DATA_W];
         end
         r_v1  <= w_gnt;
         r_ch1 <= w_gch;
         r_we1 <= WE[w_gch];
         r_v2  <= r_v1;
         r_ch2 <= r_ch1;
         r_we2 <= r_we1;
         ACK   <= '0;
         if (r_v2) begin
            ACK[r_ch2] <= 1'b1;
            if (!r_we2) RDATA[r_ch2*DATA_W +: DATA_W] <= MEM_RDATA;
         end
         r_busy <= (r_busy | (CHANNELS'(w_gnt) << w_gch)) & ~(CHANNELS'(r_v2) << r_ch2);
      end
   end
endmodule
